// File: rtl/tdm_demux_if.sv
// ============================================================================
// tdm_demux_if : serial slot stream in, per-channel parallel words out
// Rev 1.0
// ============================================================================
`default_nettype none

interface tdm_demux_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
);
  logic                         din;
  logic                         din_valid;
  logic                         frame_sync;
  logic [CHANNELS*WIDTH-1:0]    ch_data;
  logic [CHANNELS-1:0]          ch_valid;
  logic                         frame_done;
  logic                         sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  ch_data, ch_valid, frame_done, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output ch_data, ch_valid, frame_done, sync_err
  );
endinterface

`default_nettype wire

// File: rtl/tdm_demux.sv
// ============================================================================
// tdm_demux : sync-framed serial TDM receiver with framing-error detection
// Rev 1.0
// ============================================================================
`default_nettype none

module tdm_demux #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic            clock,
  input  logic            resetn,
  tdm_demux_if.slave      bus
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(CHANNELS - 1);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t                       state;
  logic [WIDTH-1:0]             shreg;
  logic [BW-1:0]                bit_cnt;
  logic [SW-1:0]                slot_cnt;
  logic [CHANNELS*WIDTH-1:0]    ch_data;
  logic [CHANNELS-1:0]          ch_valid;
  logic                         frame_done;
  logic                         sync_err;

  logic [WIDTH-1:0]             word;
  logic                         at_start;

  // Word as it will look once the current bit is shifted in
  assign word     = {shreg[WIDTH-2:0], bus.din};
  assign at_start = (bit_cnt == '0) && (slot_cnt == '0);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= HUNT;
      shreg      <= '0;
      bit_cnt    <= '0;
      slot_cnt   <= '0;
      ch_data    <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      ch_valid   <= '0;
      frame_done <= 1'b0;
      if (bus.din_valid) begin
        case (state)
          HUNT: begin
            if (bus.frame_sync) begin
              shreg    <= WIDTH'(bus.din);
              bit_cnt  <= BW'(1);
              slot_cnt <= '0;
              state    <= RECV;
            end
          end
          RECV: begin
            if (bus.frame_sync && !at_start) begin
              // Early sync: drop the partial slot and realign on this bit
              sync_err <= 1'b1;
              shreg    <= WIDTH'(bus.din);
              bit_cnt  <= BW'(1);
              slot_cnt <= '0;
            end else if (!bus.frame_sync && at_start) begin
              // Missing sync where a frame should begin: lose lock
              sync_err <= 1'b1;
              shreg    <= '0;
              state    <= HUNT;
            end else begin
              shreg <= word;
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
                for (int k = 0; k < CHANNELS; k++) begin
                  if (slot_cnt == SW'(k)) begin
                    ch_data[k*WIDTH +: WIDTH] <= word;
                    ch_valid[k]               <= 1'b1;
                  end
                end
                if (slot_cnt == SLOT_LAST) begin
                  slot_cnt   <= '0;
                  frame_done <= 1'b1;
                end else begin
                  slot_cnt <= slot_cnt + 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  assign bus.ch_data    = ch_data;
  assign bus.ch_valid   = ch_valid;
  assign bus.frame_done = frame_done;
  assign bus.sync_err   = sync_err;

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux.sv
// ============================================================================
// tb_tdm_demux : table-driven frames plus framing-error sequences, scoreboarded
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tdm_demux;

  localparam int CH = 4;
  localparam int W  = 8;

  logic clock = 1'b0;
  logic resetn;

  always #5 clock = ~clock;

  tdm_demux_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  tdm_demux #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [CH-1:0]   valid;
    logic            done;
    logic [CH*W-1:0] data;
  } exp_t;

  typedef struct {
    logic [CH*W-1:0] words;
    int              gap;
    logic [CH*W-1:0] exp_data;
  } vec_t;

  exp_t            sb[$];
  int              n_cmp = 0;
  int              n_bad = 0;
  logic [CH*W-1:0] model_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every output pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    exp_t e;
    if (bus.ch_valid != '0 || bus.frame_done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got valid=%b done=%b expected no pulse",
                 bus.ch_valid, bus.frame_done);
      end else begin
        e = sb.pop_front();
        check("pulse_valid", 32'(bus.ch_valid), 32'(e.valid));
        check("pulse_done", 32'(bus.frame_done), 32'(e.done));
        check("pulse_data", bus.ch_data, e.data);
      end
    end
  end

  task automatic send_bit(input logic b, input logic fs, input int gap);
    bus.din        = b;
    bus.frame_sync = fs;
    bus.din_valid  = 1'b1;
    @(posedge clock); #1;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    repeat (gap) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input int slot, input logic lead,
                           input int gap, input int nbits, input logic push);
    for (int i = 0; i < nbits; i++) begin
      if (push && i == W - 1) begin
        exp_t e;
        model_data[slot*W +: W] = w;
        e.valid = CH'(1 << slot);
        e.done  = (slot == CH - 1);
        e.data  = model_data;
        sb.push_back(e);
      end
      send_bit(w[W-1-i], lead && (i == 0), gap);
    end
  endtask

  task automatic send_frame(input logic [CH*W-1:0] words, input int gap, input logic lead);
    for (int k = 0; k < CH; k++)
      send_word(words[k*W +: W], k, lead && (k == 0), gap, W, 1'b1);
  endtask

  task automatic do_reset(input logic busy);
    resetn         = 1'b0;
    bus.din        = busy;
    bus.frame_sync = busy;
    bus.din_valid  = busy;
    @(posedge clock); #1;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    check("rst_ch_data", bus.ch_data, 32'h0);
    check("rst_ch_valid", 32'(bus.ch_valid), 32'h0);
    check("rst_frame_done", 32'(bus.frame_done), 32'h0);
    check("rst_sync_err", 32'(bus.sync_err), 32'h0);
    resetn     = 1'b1;
    model_data = '0;
    sb.delete();
  endtask

  task automatic drain();
    repeat (3) begin
      @(posedge clock); #1;
    end
    check("sb_drained", 32'(sb.size()), 32'h0);
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{words: 32'h01FF3CA5, gap: 0, exp_data: 32'h01FF3CA5};
    vecs[1] = '{words: 32'h01FF3CA5, gap: 2, exp_data: 32'h01FF3CA5};
    vecs[2] = '{words: 32'h80000001, gap: 1, exp_data: 32'h80000001};
    vecs[3] = '{words: 32'hFFFFFFFF, gap: 0, exp_data: 32'hFFFFFFFF};

    resetn         = 1'b0;
    bus.din        = 1'b0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    model_data     = '0;
    @(posedge clock); #1;

    for (int v = 0; v < 4; v++) begin
      do_reset(1'b0);
      send_frame(vecs[v].words, vecs[v].gap, 1'b1);
      drain();
      check("vec_ch_data", bus.ch_data, vecs[v].exp_data);
      check("vec_sync_err", 32'(bus.sync_err), 32'h0);
    end

    // Back-to-back frames with no idle bit between them
    do_reset(1'b0);
    send_frame(32'h01FF3CA5, 0, 1'b1);
    send_frame(32'h44332211, 0, 1'b1);
    drain();
    check("b2b_ch_data", bus.ch_data, 32'h44332211);
    check("b2b_sync_err", 32'(bus.sync_err), 32'h0);

    // Stray frame_sync on bit 3 of slot 1
    do_reset(1'b0);
    send_word(8'h77, 0, 1'b1, 0, W, 1'b1);
    send_word(8'h99, 1, 1'b0, 0, 3, 1'b0);
    send_frame(32'h0D0C0B0A, 0, 1'b1);
    drain();
    check("stray_sync_err", 32'(bus.sync_err), 32'h1);
    check("stray_ch_data", bus.ch_data, 32'h0D0C0B0A);

    // Missing frame_sync after a good frame, then unsynced bits are ignored
    do_reset(1'b0);
    send_frame(32'h01FF3CA5, 0, 1'b1);
    send_word(8'hAA, 0, 1'b0, 0, W, 1'b0);
    for (int k = 0; k < CH; k++) send_word(8'h55, k, 1'b0, 0, W, 1'b0);
    drain();
    check("nosync_sync_err", 32'(bus.sync_err), 32'h1);
    check("nosync_ch_data", bus.ch_data, 32'h01FF3CA5);
    send_frame(32'h12345678, 1, 1'b1);
    drain();
    check("relock_ch_data", bus.ch_data, 32'h12345678);
    check("relock_sync_err", 32'(bus.sync_err), 32'h1);

    // Reset in the middle of slot 2, then a clean frame
    do_reset(1'b0);
    send_word(8'h11, 0, 1'b1, 0, W, 1'b1);
    send_word(8'h22, 1, 1'b0, 0, W, 1'b1);
    send_word(8'h33, 2, 1'b0, 0, 4, 1'b0);
    drain();
    do_reset(1'b1);
    send_frame(32'h5D5C5B5A, 0, 1'b1);
    drain();
    check("post_rst_ch_data", bus.ch_data, 32'h5D5C5B5A);
    check("post_rst_sync_err", 32'(bus.sync_err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
